// File: rtl/sdio_cmd52_engine.sv
// CMD52 (IO_RW_DIRECT) initiator: validates function/address, drives one write
// and/or read access on the per-function register bus, and returns R5 data + flags.
module sdio_cmd52_engine #(
    parameter int NUM_FUNCS       = 1,
    parameter int FUNC_ADDR_WIDTH = 8,
    parameter int READ_LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_stb,
    input  logic [31:0] i_cmd_arg,
    output logic        o_cmd_busy,
    input  logic [7:0]  i_func_enable,
    input  logic [1:0]  i_io_state,
    output logic [7:0]  o_activate,
    output logic        o_write_flag,
    output logic [16:0] o_address,
    output logic        o_data_stb,
    output logic [7:0]  o_data_out,
    input  logic [7:0]  i_data_in,
    output logic        o_rsp_stb,
    output logic [7:0]  o_rsp_data,
    output logic [7:0]  o_rsp_flags
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WRITE, S_READ, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] LAT      = 3'(READ_LATENCY);
    localparam logic [2:0] MAX_FUNC = 3'(NUM_FUNCS);

    state_t      state_q, state_d;
    logic        rw_q, rw_d, raw_q, raw_d;
    logic [2:0]  func_q, func_d;
    logic [16:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d, rdata_q, rdata_d;
    logic        ferr_q, ferr_d, rerr_q, rerr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        func_err, range_err;

    // Stuff bit and the reserved argument bit carry no information here.
    logic unused_arg_bits;
    assign unused_arg_bits = i_cmd_arg[26] ^ i_cmd_arg[8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rw_q    <= 1'b0;
            raw_q   <= 1'b0;
            func_q  <= 3'd0;
            addr_q  <= 17'd0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
            ferr_q  <= 1'b0;
            rerr_q  <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            raw_q   <= raw_d;
            func_q  <= func_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ferr_q  <= ferr_d;
            rerr_q  <= rerr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Function 0 (CIA) is always present and uses the full 17-bit address space.
    assign func_err  = (func_q > MAX_FUNC) || ((func_q != 3'd0) && !i_func_enable[func_q]);
    assign range_err = (func_q != 3'd0) && ((addr_q >> FUNC_ADDR_WIDTH) != 17'd0);

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        raw_d   = raw_q;
        func_d  = func_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ferr_d  = ferr_q;
        rerr_d  = rerr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_cmd_stb) begin
                    rw_d    = i_cmd_arg[31];
                    func_d  = i_cmd_arg[30:28];
                    raw_d   = i_cmd_arg[27];
                    addr_d  = i_cmd_arg[25:9];
                    wdata_d = i_cmd_arg[7:0];
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ferr_d = func_err;
                rerr_d = range_err;
                if (func_err || range_err) begin
                    rdata_d = 8'd0;
                    state_d = S_RESP;
                end else begin
                    state_d = rw_q ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (raw_q) begin
                    state_d = S_READ;
                end else begin
                    rdata_d = wdata_q;
                    state_d = S_RESP;
                end
            end
            S_READ: begin
                cnt_d   = 3'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == LAT) begin
                    rdata_d = i_data_in;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign o_cmd_busy   = (state_q != S_IDLE);
    assign o_data_stb   = (state_q == S_WRITE) || (state_q == S_READ);
    assign o_write_flag = (state_q == S_WRITE);
    assign o_activate   = (o_data_stb || state_q == S_WAIT) ? (8'd1 << func_q) : 8'd0;
    assign o_address    = addr_q;
    assign o_data_out   = wdata_q;
    assign o_rsp_stb    = (state_q == S_RESP);
    assign o_rsp_data   = o_rsp_stb ? rdata_q : 8'd0;
    assign o_rsp_flags  = o_rsp_stb ? {2'b00, i_io_state, 2'b00, ferr_q, rerr_q} : 8'd0;

endmodule

// File: tb/tb_sdio_cmd52_engine.sv
// Directed bench for sdio_cmd52_engine: a per-cycle expected-output timeline built
// from the command rules, checked every cycle, plus literal per-command expectations.
module tb_sdio_cmd52_engine;
    localparam int NF  = 1;
    localparam int FAW = 8;
    localparam int L   = 1;
    localparam int TL  = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cmd_stb;
    logic [31:0] i_cmd_arg;
    logic        o_cmd_busy;
    logic [7:0]  i_func_enable;
    logic [1:0]  i_io_state;
    logic [7:0]  o_activate;
    logic        o_write_flag;
    logic [16:0] o_address;
    logic        o_data_stb;
    logic [7:0]  o_data_out;
    logic [7:0]  i_data_in;
    logic        o_rsp_stb;
    logic [7:0]  o_rsp_data;
    logic [7:0]  o_rsp_flags;

    sdio_cmd52_engine #(.NUM_FUNCS(NF), .FUNC_ADDR_WIDTH(FAW), .READ_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .i_cmd_stb(i_cmd_stb), .i_cmd_arg(i_cmd_arg),
        .o_cmd_busy(o_cmd_busy), .i_func_enable(i_func_enable), .i_io_state(i_io_state),
        .o_activate(o_activate), .o_write_flag(o_write_flag), .o_address(o_address),
        .o_data_stb(o_data_stb), .o_data_out(o_data_out), .i_data_in(i_data_in),
        .o_rsp_stb(o_rsp_stb), .o_rsp_data(o_rsp_data), .o_rsp_flags(o_rsp_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected-output timeline, indexed by cycle number.
    logic        e_busy [TL];
    logic        e_stb  [TL];
    logic        e_wf   [TL];
    logic [16:0] e_addr [TL];
    logic [7:0]  e_dout [TL];
    logic [7:0]  e_act  [TL];
    logic        e_rsp  [TL];
    logic [7:0]  e_rdata[TL];
    logic [7:0]  e_rflag[TL];

    logic [7:0] mmem [int];  // model's view of register contents
    logic [7:0] rmem [int];  // responder's register contents
    logic [1:0] io_st;
    logic       chk_en = 1'b0;

    task automatic clear_from(input int c);
        for (int k = c; k < TL; k++) begin
            e_busy[k] = 0; e_stb[k] = 0; e_wf[k] = 0; e_addr[k] = 0; e_dout[k] = 0;
            e_act[k] = 0; e_rsp[k] = 0; e_rdata[k] = 0; e_rflag[k] = 0;
        end
    endtask

    task automatic model_cmd(input int c0, input logic [31:0] a);
        logic        rw, raw, ferr, rerr, rd;
        logic [2:0]  f;
        logic [16:0] ad;
        logic [7:0]  wd, oh, d;
        int          key, r, rs;
        rw = a[31]; f = a[30:28]; raw = a[27]; ad = a[25:9]; wd = a[7:0];
        oh   = 8'd1 << f;
        key  = int'(f) * 131072 + int'(ad);
        ferr = (int'(f) > NF) || (f != 0 && !i_func_enable[f]);
        rerr = (f != 0) && (int'(ad) >= (1 << FAW));
        rd = 0; rs = 0; d = 0;
        if (ferr || rerr) begin
            r = c0 + 2;
        end else begin
            if (rw) begin
                e_stb[c0+2] = 1; e_wf[c0+2] = 1; e_addr[c0+2] = ad; e_dout[c0+2] = wd;
                e_act[c0+2] = oh;
                mmem[key] = wd;
            end
            if (rw && raw) begin rd = 1; rs = c0 + 3; end
            else if (!rw) begin rd = 1; rs = c0 + 2; end
            if (rd) begin
                e_stb[rs] = 1; e_wf[rs] = 0; e_addr[rs] = ad; e_act[rs] = oh;
                for (int k = rs + 1; k <= rs + L; k++) e_act[k] = oh;
                r = rs + L + 1;
                d = mmem.exists(key) ? mmem[key] : 8'h00;
            end else begin
                r = c0 + 3;
                d = wd;
            end
        end
        for (int k = c0 + 1; k <= r; k++) e_busy[k] = 1;
        e_rsp[r] = 1; e_rdata[r] = d; e_rflag[r] = {2'b00, io_st, 2'b00, ferr, rerr};
    endtask

    // Responder: register files of the selected function.
    always @(negedge clk) begin
        if (!rst && o_data_stb) begin
            int f, key;
            f = 0;
            for (int i = 0; i < 8; i++) if (o_activate[i]) f = i;
            key = f * 131072 + int'(o_address);
            if (o_write_flag) begin
                rmem[key] = o_data_out;
            end else begin
                repeat (L) @(posedge clk);
                #1 i_data_in = rmem.exists(key) ? rmem[key] : 8'h00;
            end
        end
    end

    int         rsp_cnt = 0;
    int         rsp_cyc = -1;
    int         wstb_cyc = -1;
    int         rstb_cyc = -1;
    logic [7:0] last_rdata = 0;
    logic [7:0] last_rflags = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(o_cmd_busy), 32'(e_busy[cyc]));
            chk("data_stb", 32'(o_data_stb), 32'(e_stb[cyc]));
            chk("activate", 32'(o_activate), 32'(e_act[cyc]));
            chk("rsp_stb", 32'(o_rsp_stb), 32'(e_rsp[cyc]));
            if (e_stb[cyc]) begin
                chk("write_flag", 32'(o_write_flag), 32'(e_wf[cyc]));
                chk("address", 32'(o_address), 32'(e_addr[cyc]));
                if (e_wf[cyc]) chk("data_out", 32'(o_data_out), 32'(e_dout[cyc]));
            end
            if (e_rsp[cyc]) begin
                chk("rsp_data", 32'(o_rsp_data), 32'(e_rdata[cyc]));
                chk("rsp_flags", 32'(o_rsp_flags), 32'(e_rflag[cyc]));
            end
            if (o_rsp_stb) begin
                rsp_cnt++; rsp_cyc = cyc; last_rdata = o_rsp_data; last_rflags = o_rsp_flags;
            end
            if (o_data_stb) begin
                if (o_write_flag) wstb_cyc = cyc; else rstb_cyc = cyc;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic accept);
        i_cmd_stb = 1'b1;
        i_cmd_arg = a;
        if (accept) model_cmd(cyc, a);
        @(posedge clk); #1;
        i_cmd_stb = 1'b0;
        i_cmd_arg = 32'h0;
    endtask

    task automatic run(input string nm, input logic [31:0] a, input logic [7:0] xd,
                       input logic [7:0] xf, input int xlat);
        int c0, n0;
        c0 = cyc; n0 = rsp_cnt;
        send(a, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk({nm, ".count"}, 32'(rsp_cnt - n0), 32'd1);
        chk({nm, ".data"}, 32'(last_rdata), 32'(xd));
        chk({nm, ".flags"}, 32'(last_rflags), 32'(xf));
        chk({nm, ".latency"}, 32'(rsp_cyc - c0), 32'(xlat));
    endtask

    initial begin
        int c0, n0;
        rst = 1'b1; i_cmd_stb = 1'b0; i_cmd_arg = 32'h0; i_data_in = 8'h00;
        i_func_enable = 8'h02; i_io_state = 2'b00; io_st = 2'b00;
        clear_from(0);
        mmem[0*131072 + 'h10] = 8'hA5; rmem[0*131072 + 'h10] = 8'hA5;
        mmem[1*131072 + 'h20] = 8'h77; rmem[1*131072 + 'h20] = 8'h77;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.busy", 32'(o_cmd_busy), 32'd0);
        chk("reset.activate", 32'(o_activate), 32'd0);
        chk("reset.data_stb", 32'(o_data_stb), 32'd0);
        chk("reset.rsp_stb", 32'(o_rsp_stb), 32'd0);
        chk("reset.rsp_data", 32'(o_rsp_data), 32'd0);
        chk("reset.rsp_flags", 32'(o_rsp_flags), 32'd0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // write f1 addr 0x08 data 0x55
        c0 = cyc;
        run("write", 32'h9000_1055, 8'h55, 8'h00, 3);
        chk("write.strobe_cycle", 32'(wstb_cyc - c0), 32'd2);
        // read f0 addr 0x10
        c0 = cyc;
        run("read_f0", 32'h0000_2000, 8'hA5, 8'h00, 4);
        chk("read_f0.strobe_cycle", 32'(rstb_cyc - c0), 32'd2);
        // RAW write 0x3C to f1 addr 0x10
        c0 = cyc;
        run("raw", 32'h9800_203C, 8'h3C, 8'h00, 5);
        chk("raw.wstrobe_cycle", 32'(wstb_cyc - c0), 32'd2);
        chk("raw.rstrobe_cycle", 32'(rstb_cyc - c0), 32'd3);
        // error cases
        run("func3", 32'h3000_0000, 8'h00, 8'h02, 2);
        i_func_enable = 8'h00;
        run("f1_disabled", 32'h1000_0000, 8'h00, 8'h02, 2);
        i_func_enable = 8'h02;
        run("range", 32'h1002_0000, 8'h00, 8'h01, 2);
        io_st = 2'b10; i_io_state = 2'b10;
        run("both_err", 32'h3002_0000, 8'h00, 8'h23, 2);
        run("read_f1_io2", 32'h1000_4000, 8'h77, 8'h20, 4);
        io_st = 2'b00; i_io_state = 2'b00;
        // RAW with R/W=0 is a plain read
        run("raw_read", 32'h0800_2000, 8'hA5, 8'h00, 4);

        // stb while busy and in the RESP cycle is ignored; IDLE accepts the next one
        n0 = rsp_cnt;
        send(32'h9000_1066, 1'b1);
        send(32'h9000_10EE, 1'b0);
        send(32'h9000_10EE, 1'b0);
        send(32'h9000_10EE, 1'b0);
        send(32'h1000_1000, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_ignore.count", 32'(rsp_cnt - n0), 32'd2);
        chk("busy_ignore.data", 32'(last_rdata), 32'h66);

        // reset during WAIT aborts without a response
        n0 = rsp_cnt;
        send(32'h0000_2000, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        clear_from(cyc + 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort.count", 32'(rsp_cnt - n0), 32'd0);
        run("after_abort", 32'h0000_2000, 8'hA5, 8'h00, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
